// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one ALU among NUM_REQ requesters.
//  - Picks one requester through a valid/ready handshake.
//  - Drives the ALU operand bus from registers.
//  - Samples the ALU results ALU_LAT edges later.
//  - Returns them, tagged with the requester id, on a valid/ready response port.
// Configuration macro: ALU_ARB_FIXED_PRIO_EN
//  - defined:   fixed priority, the lowest asserted index wins.
//  - undefined: round-robin (the default).
`timescale 1ns/1ps

module alu_req_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int ALU_LAT = 1,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,          // asynchronous, active-low
  // requester side
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [4*NUM_REQ-1:0] req_op_code,
  input  logic [8*NUM_REQ-1:0] req_src1,
  input  logic [8*NUM_REQ-1:0] req_src2,
  input  logic [8*NUM_REQ-1:0] req_src3,
  input  logic [NUM_REQ-1:0]   req_srcCy,
  input  logic [NUM_REQ-1:0]   req_srcAc,
  input  logic [NUM_REQ-1:0]   req_bit_in,
  // ALU operand bus
  output logic [3:0]           alu_op_code,
  output logic [7:0]           alu_src1,
  output logic [7:0]           alu_src2,
  output logic [7:0]           alu_src3,
  output logic                 alu_srcCy,
  output logic                 alu_srcAc,
  output logic                 alu_bit_in,
  // ALU results
  input  logic [7:0]           alu_des1,
  input  logic [7:0]           alu_des2,
  input  logic [7:0]           alu_des_acc,
  input  logic                 alu_desCy,
  input  logic                 alu_desAc,
  input  logic                 alu_desOv,
  // status and response side
  output logic                 busy,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [7:0]           rsp_des1,
  output logic [7:0]           rsp_des2,
  output logic [7:0]           rsp_des_acc,
  output logic [2:0]           rsp_flags
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [3:0]     r_cnt;
  logic [IDW-1:0] r_id;

  logic [3:0]     r_alu_op_code;
  logic [7:0]     r_alu_src1;
  logic [7:0]     r_alu_src2;
  logic [7:0]     r_alu_src3;
  logic           r_alu_srcCy;
  logic           r_alu_srcAc;
  logic           r_alu_bit_in;

  logic           r_rsp_valid;
  logic [7:0]     r_rsp_des1;
  logic [7:0]     r_rsp_des2;
  logic [7:0]     r_rsp_des_acc;
  logic [2:0]     r_rsp_flags;

  logic           w_grant_vld;
  logic [IDW-1:0] w_grant_idx;
  logic           w_accept;
  logic           w_done;
  logic           w_retire;

  logic [3:0]     w_sel_op_code;
  logic [7:0]     w_sel_src1;
  logic [7:0]     w_sel_src2;
  logic [7:0]     w_sel_src3;
  logic           w_sel_srcCy;
  logic           w_sel_srcAc;
  logic           w_sel_bit_in;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef ALU_ARB_FIXED_PRIO_EN
  // Fixed priority: scan from the top index down, so the lowest asserted index wins.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] r_ptr;

  // Round-robin: the first valid index after the last winner, wrapping modulo NUM_REQ.
  //  - Offsets are scanned from far to near, so the nearest valid requester wins.
  always_comb begin
    int idx;
    // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    idx         = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = int'(r_ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = IDW'(idx);
      end
    end
  end

  // Pointer register: remembers the last winner.
  //  - Its reset value NUM_REQ-1 makes requester 0 the first to win.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= IDW'(NUM_REQ - 1);
    end else if (w_accept) begin
      r_ptr <= w_grant_idx;
    end
  end
`endif

  assign w_accept = (r_state == ST_IDLE) && w_grant_vld;
  assign w_done   = (r_state == ST_WAIT) && (r_cnt == 4'd1);
  assign w_retire = (r_state == ST_RESP) && rsp_ready;

  // Ready is one-hot on the winner, and only while IDLE and out of reset.
  always_comb begin
    req_ready = '0;
    if (rst && (r_state == ST_IDLE) && w_grant_vld) begin
      req_ready[w_grant_idx] = 1'b1;
    end
  end

  // Operand mux: slices out the winning requester's packed operand fields.
  always_comb begin
    int gi;
    gi            = int'(w_grant_idx);
    w_sel_op_code = req_op_code[4*gi +: 4];
    w_sel_src1    = req_src1[8*gi +: 8];
    w_sel_src2    = req_src2[8*gi +: 8];
    w_sel_src3    = req_src3[8*gi +: 8];
    w_sel_srcCy   = req_srcCy[gi];
    w_sel_srcAc   = req_srcAc[gi];
    w_sel_bit_in  = req_bit_in[gi];
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment, so every register samples pre-edge values.
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  //  - RESP returns to IDLE without accepting, so back-to-back ops are ALU_LAT+2 cycles apart.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_grant_vld) w_state_nxt = ST_WAIT;
      ST_WAIT: if (r_cnt == 4'd1) w_state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latency counter: loaded on accept, counts down while waiting on the ALU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= 4'(ALU_LAT);
    end else if (r_state == ST_WAIT) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // Operand registers and served id.
  //  - Loaded only on accept, so the ALU bus holds its last values between ops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: these datapath registers are reset on purpose; the ALU bus must read zero during reset.
      r_alu_op_code <= 4'd0;
      r_alu_src1    <= 8'd0;
      r_alu_src2    <= 8'd0;
      r_alu_src3    <= 8'd0;
      r_alu_srcCy   <= 1'b0;
      r_alu_srcAc   <= 1'b0;
      r_alu_bit_in  <= 1'b0;
      r_id          <= '0;
    end else if (w_accept) begin
      r_alu_op_code <= w_sel_op_code;
      r_alu_src1    <= w_sel_src1;
      r_alu_src2    <= w_sel_src2;
      r_alu_src3    <= w_sel_src3;
      r_alu_srcCy   <= w_sel_srcCy;
      r_alu_srcAc   <= w_sel_srcAc;
      r_alu_bit_in  <= w_sel_bit_in;
      r_id          <= w_grant_idx;
    end
  end

  // Response registers.
  //  - Results are captured on the last WAIT edge and held stable through RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_des1    <= 8'd0;
      r_rsp_des2    <= 8'd0;
      r_rsp_des_acc <= 8'd0;
      r_rsp_flags   <= 3'd0;
    end else if (w_done) begin
      r_rsp_valid   <= 1'b1;
      r_rsp_des1    <= alu_des1;
      r_rsp_des2    <= alu_des2;
      r_rsp_des_acc <= alu_des_acc;
      r_rsp_flags   <= {alu_desOv, alu_desAc, alu_desCy};
    end else if (w_retire) begin
      r_rsp_valid   <= 1'b0;
    end
  end

  assign alu_op_code = r_alu_op_code;
  assign alu_src1    = r_alu_src1;
  assign alu_src2    = r_alu_src2;
  assign alu_src3    = r_alu_src3;
  assign alu_srcCy   = r_alu_srcCy;
  assign alu_srcAc   = r_alu_srcAc;
  assign alu_bit_in  = r_alu_bit_in;

  assign busy        = (r_state != ST_IDLE);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_id;
  assign rsp_des1    = r_rsp_des1;
  assign rsp_des2    = r_rsp_des2;
  assign rsp_des_acc = r_rsp_des_acc;
  assign rsp_flags   = r_rsp_flags;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Testbench for alu_req_arbiter: directed vectors with hand-computed results.
//  - Two instances: ALU_LAT=1 (main) and ALU_LAT=3 (latency check).
//  - Each instance drives its own behavioural ALU stand-in.
`timescale 1ns/1ps

module tb_alu_req_arbiter;

  localparam int NR  = 4;
  localparam int IDW = 2;

  typedef struct packed {
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] acc;
    logic       ov;
    logic       ac;
    logic       cy;
  } alu_res_t;

  // ALU stand-in.
  //  - op 1 adds with carry, half-carry and overflow flags.
  //  - Every other op is a bitwise AND that passes the flags through.
  function automatic alu_res_t alu_model(input logic [3:0] op, input logic [7:0] a, b, c,
                                         input logic cy, ac, bi);
    alu_res_t   r;
    logic [8:0] s;
    logic [4:0] n;
    r.d1 = a ^ b;
    r.d2 = c;
    if (op == 4'h1) begin
      s     = {1'b0, a} + {1'b0, b};
      n     = {1'b0, a[3:0]} + {1'b0, b[3:0]};
      r.acc = s[7:0];
      r.cy  = s[8];
      r.ac  = n[4];
      r.ov  = (a[7] == b[7]) && (s[7] != a[7]);
    end else begin
      r.acc = a & b;
      r.cy  = cy;
      r.ac  = ac;
      r.ov  = bi;
    end
    return r;
  endfunction

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // shared requester operand buses
  logic [4*NR-1:0] req_op_code;
  logic [8*NR-1:0] req_src1, req_src2, req_src3;
  logic [NR-1:0]   req_srcCy, req_srcAc, req_bit_in;

  // instance 1 (ALU_LAT=1)
  logic [NR-1:0]  req_valid, req_ready;
  logic [3:0]     a_op;
  logic [7:0]     a_s1, a_s2, a_s3;
  logic           a_cy, a_ac, a_bi;
  alu_res_t       m1;
  logic           busy, rsp_valid, rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [7:0]     rsp_des1, rsp_des2, rsp_des_acc;
  logic [2:0]     rsp_flags;

  // instance 3 (ALU_LAT=3)
  logic [NR-1:0]  req_valid3, req_ready3;
  logic [3:0]     b_op;
  logic [7:0]     b_s1, b_s2, b_s3;
  logic           b_cy, b_ac, b_bi;
  alu_res_t       m3;
  logic           busy3, rsp_valid3, rsp_ready3;
  logic [IDW-1:0] rsp_id3;
  logic [7:0]     rsp_des1_3, rsp_des2_3, rsp_des_acc3;
  logic [2:0]     rsp_flags3;

  assign m1 = alu_model(a_op, a_s1, a_s2, a_s3, a_cy, a_ac, a_bi);
  assign m3 = alu_model(b_op, b_s1, b_s2, b_s3, b_cy, b_ac, b_bi);

  alu_req_arbiter #(.NUM_REQ(NR), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_code(req_op_code), .req_src1(req_src1), .req_src2(req_src2), .req_src3(req_src3),
    .req_srcCy(req_srcCy), .req_srcAc(req_srcAc), .req_bit_in(req_bit_in),
    .alu_op_code(a_op), .alu_src1(a_s1), .alu_src2(a_s2), .alu_src3(a_s3),
    .alu_srcCy(a_cy), .alu_srcAc(a_ac), .alu_bit_in(a_bi),
    .alu_des1(m1.d1), .alu_des2(m1.d2), .alu_des_acc(m1.acc),
    .alu_desCy(m1.cy), .alu_desAc(m1.ac), .alu_desOv(m1.ov),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_des1(rsp_des1), .rsp_des2(rsp_des2), .rsp_des_acc(rsp_des_acc), .rsp_flags(rsp_flags)
  );

  alu_req_arbiter #(.NUM_REQ(NR), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_op_code(req_op_code), .req_src1(req_src1), .req_src2(req_src2), .req_src3(req_src3),
    .req_srcCy(req_srcCy), .req_srcAc(req_srcAc), .req_bit_in(req_bit_in),
    .alu_op_code(b_op), .alu_src1(b_s1), .alu_src2(b_s2), .alu_src3(b_s3),
    .alu_srcCy(b_cy), .alu_srcAc(b_ac), .alu_bit_in(b_bi),
    .alu_des1(m3.d1), .alu_des2(m3.d2), .alu_des_acc(m3.acc),
    .alu_desCy(m3.cy), .alu_desAc(m3.ac), .alu_desOv(m3.ov),
    .busy(busy3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3),
    .rsp_des1(rsp_des1_3), .rsp_des2(rsp_des2_3), .rsp_des_acc(rsp_des_acc3), .rsp_flags(rsp_flags3)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int exp_q[$];
  logic [7:0] rr_acc [NR] = '{8'h01, 8'h12, 8'h23, 8'h34};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [7:0] s1, s2, s3);
    req_op_code[4*i +: 4] = op;
    req_src1[8*i +: 8]    = s1;
    req_src2[8*i +: 8]    = s2;
    req_src3[8*i +: 8]    = s3;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 20 && req_ready == '0; i++) @(negedge clk);
    check(tag, 32'(req_ready != '0), 32'd1);
  endtask

  task automatic wait_rsp(input string tag);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    check(tag, 32'(rsp_valid), 32'd1);
  endtask

  // Holds vld with rsp_ready=1 and checks n grants.
  //  - Expected winners come from exp_q; consecutive grants must be 3 cycles apart.
  task automatic run_seq(input logic [NR-1:0] vld, input int n);
    int last;
    int e;
    last      = -1;
    req_valid = vld;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < n; k++) begin
      e = exp_q[k];
      wait_ready("seq_ready_timeout");
      check("seq_grant", 32'(req_ready), 32'(1 << e));
      if (last >= 0) check("seq_interval", 32'(cyc - last), 32'd3);
      last = cyc;
      @(negedge clk);
      wait_rsp("seq_rsp_timeout");
      check("seq_id", 32'(rsp_id), 32'(e));
      check("seq_acc", 32'(rsp_des_acc), 32'(rr_acc[e]));
      if (k == n - 1) req_valid = '0;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b0;
    req_valid   = 4'hF;
    req_valid3  = '0;
    rsp_ready   = 1'b0;
    rsp_ready3  = 1'b0;
    req_op_code = '0;
    req_src1    = '0;
    req_src2    = '0;
    req_src3    = '0;
    req_srcCy   = '0;
    req_srcAc   = '0;
    req_bit_in  = '0;
    repeat (3) @(negedge clk);

    // reset state, with every requester asking
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_alu_src1", 32'(a_s1), 32'h0);
    req_valid = '0;
    rst       = 1'b1;
    @(negedge clk);

    // single op: requester 2 computes 05 + 03
    set_req(2, 4'h1, 8'h05, 8'h03, 8'h00);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1;
    check("single_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    req_valid = '0;
    check("single_alu_src1", 32'(a_s1), 32'h05);
    check("single_alu_src2", 32'(a_s2), 32'h03);
    check("single_alu_op", 32'(a_op), 32'h1);
    check("single_busy", 32'(busy), 32'h1);
    check("single_no_rsp_yet", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    check("single_rsp_valid", 32'(rsp_valid), 32'h1);
    check("single_rsp_id", 32'(rsp_id), 32'h2);
    check("single_acc", 32'(rsp_des_acc), 32'h08);
    check("single_des1", 32'(rsp_des1), 32'h06);
    check("single_flags", 32'(rsp_flags), 32'h0);
    @(negedge clk);
    check("single_done_valid", 32'(rsp_valid), 32'h0);
    check("single_done_busy", 32'(busy), 32'h0);

    // reset asserted mid-WAIT drops the op at once
    set_req(1, 4'h1, 8'h22, 8'h01, 8'h00);
    req_valid = 4'b0010;
    #1;
    check("rstwait_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    check("rstwait_busy_before", 32'(busy), 32'h1);
    rst = 1'b0;
    #1;
    check("rstwait_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rstwait_busy", 32'(busy), 32'h0);
    check("rstwait_alu_src1", 32'(a_s1), 32'h0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    set_req(3, 4'h1, 8'h33, 8'h01, 8'h00);
    req_valid = 4'b1000;
    #1;
    check("postrst_ready", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    check("postrst_rsp_valid", 32'(rsp_valid), 32'h1);
    check("postrst_id", 32'(rsp_id), 32'h3);
    check("postrst_acc", 32'(rsp_des_acc), 32'h34);
    @(negedge clk);

    // all requesters held valid
    for (int i = 0; i < NR; i++) set_req(i, 4'h1, 8'(16 * i + 1), 8'(i), 8'h00);
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_q = '{0, 0, 0, 0, 0};
`else
    exp_q = '{0, 1, 2, 3, 0};
`endif
    run_seq(4'b1111, 5);

    // backpressure: the response is held and everyone else stalls
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    #1;
    wait_ready("bp_ready_timeout");
    check("bp_grant", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 4'b0110;
    wait_rsp("bp_rsp_timeout");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(rsp_valid), 32'h1);
      check("bp_hold_acc", 32'(rsp_des_acc), 32'h01);
      check("bp_stall_ready", 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(rsp_valid), 32'h0);
    check("bp_release_busy", 32'(busy), 32'h0);
    check("bp_no_same_cycle_accept", 32'(a_s1), 32'h01);
    check("bp_next_ready", 32'(req_ready), 32'h2);
    req_valid = '0;
    @(negedge clk);

    // requesters 0 and 2 held valid
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_q = '{0, 0, 0};
`else
    exp_q = '{2, 0, 2};
`endif
    run_seq(4'b0101, 3);

    // ALU_LAT=3 instance: response three edges after accept, flags captured
    set_req(0, 4'h1, 8'hFF, 8'h01, 8'h00);
    set_req(1, 4'h1, 8'h7F, 8'h01, 8'h00);
    rsp_ready3 = 1'b1;
    req_valid3 = 4'b0001;
    #1;
    check("lat3_ready0", 32'(req_ready3), 32'h1);
    @(negedge clk);
    req_valid3 = '0;
    check("lat3_alu_src1", 32'(b_s1), 32'hFF);
    check("lat3_n1_valid", 32'(rsp_valid3), 32'h0);
    @(negedge clk);
    check("lat3_n2_valid", 32'(rsp_valid3), 32'h0);
    @(negedge clk);
    check("lat3_n3_valid", 32'(rsp_valid3), 32'h0);
    @(negedge clk);
    check("lat3_valid", 32'(rsp_valid3), 32'h1);
    check("lat3_flags_a", 32'(rsp_flags3), 32'h3);
    check("lat3_acc_a", 32'(rsp_des_acc3), 32'h00);
    check("lat3_id_a", 32'(rsp_id3), 32'h0);
    @(negedge clk);
    req_valid3 = 4'b0010;
    #1;
    check("lat3_ready1", 32'(req_ready3), 32'h2);
    @(negedge clk);
    req_valid3 = '0;
    repeat (3) @(negedge clk);
    check("lat3_valid_b", 32'(rsp_valid3), 32'h1);
    check("lat3_flags_b", 32'(rsp_flags3), 32'h6);
    check("lat3_acc_b", 32'(rsp_des_acc3), 32'h80);
    check("lat3_id_b", 32'(rsp_id3), 32'h1);
    @(negedge clk);
    check("lat3_idle", 32'(busy3), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
